snn_tick_scheduler: RTL

// - Sequencer in front of snn_core. Streams a full weight set into the core's programming port,

---
 rtl/snn_pkg.sv | 30 +++
 rtl/snn_gap_timer.sv | 32 +++
 rtl/snn_tick_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN tick scheduler.
package snn_pkg;

    localparam int DEF_NUM_INPUTS = 256;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_W_W        = 8;
    localparam int DEF_STEP_W     = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_GAP_CYCLES = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_TICK      = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_WAIT_FALL = 3'd4,
        S_GAP       = 3'd5,
        S_FINISH    = 3'd6
    } sched_state_t;

    // Fire edges are counted across the whole tick loop so an edge coinciding
    // with the busy rise is not lost.
    function automatic logic in_run(input sched_state_t s);
        case (s)
            S_TICK, S_WAIT_RISE, S_WAIT_FALL, S_GAP: in_run = 1'b1;
            default:                                 in_run = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/snn_gap_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap between ticks.
module snn_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count down to zero after each load and park there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (srst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/snn_tick_scheduler.sv
// Command-driven sequencer: streams a weight set into snn_core, then runs N ticks.
module snn_tick_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int W_W        = DEF_W_W,
    parameter int STEP_W     = DEF_STEP_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [W_W-1:0]    wt_data,
    input  logic              run_start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              abort,
    output logic              program_mode,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [W_W-1:0]    prog_data,
    output logic              prog_wr_en,
    output logic              start_tick,
    input  logic              core_busy,
    input  logic              neuron_fire,
    output logic [STEP_W-1:0] step_idx,
    output logic [CNT_W-1:0]  fire_count,
    output logic              sched_busy,
    output logic              done
);

    localparam int TMR_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_INPUTS - 1);

    sched_state_t      state_r, next_state_s;
    logic [ADDR_W-1:0] beat_r;
    logic [STEP_W-1:0] num_steps_r, step_idx_r, step_next_s;
    logic [CNT_W-1:0]  fire_count_r;
    logic              fire_prev_r;
    logic              wt_ready_r, program_mode_r, prog_wr_en_r, start_tick_r;
    logic              sched_busy_r, done_r;
    logic [ADDR_W-1:0] prog_addr_r;
    logic [W_W-1:0]    prog_data_r;
    logic              beat_acc_s, gap_load_s, gap_zero_s, run_go_s, step_done_s;

    snn_gap_timer #(.W(TMR_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .srst     (abort),
        .load     (gap_load_s),
        .load_val (GAP_LOAD),
        .zero     (gap_zero_s)
    );

    // Next-state decode; abort overrides every non-idle state.
    always_comb begin
        next_state_s = state_r;
        beat_acc_s   = 1'b0;
        gap_load_s   = 1'b0;
        run_go_s     = 1'b0;
        step_done_s  = 1'b0;
        step_next_s  = step_idx_r + {{(STEP_W-1){1'b0}}, 1'b1};
        if (abort && (state_r != S_IDLE)) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (load_start) begin
                        next_state_s = S_LOAD;
                    end else if (run_start && !core_busy) begin
                        run_go_s     = 1'b1;
                        next_state_s = (num_steps != {STEP_W{1'b0}}) ? S_TICK : S_FINISH;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (wt_valid && wt_ready_r) begin
                        beat_acc_s   = 1'b1;
                        next_state_s = (beat_r == LAST_BEAT) ? S_FINISH : S_LOAD;
                    end else begin
                        next_state_s = S_LOAD;
                    end
                end
                S_TICK: next_state_s = S_WAIT_RISE;
                S_WAIT_RISE: begin
                    if (core_busy) begin
                        next_state_s = S_WAIT_FALL;
                    end else begin
                        next_state_s = S_WAIT_RISE;
                    end
                end
                S_WAIT_FALL: begin
                    if (!core_busy) begin
                        step_done_s = 1'b1;
                        if (step_next_s == num_steps_r) begin
                            next_state_s = S_FINISH;
                        end else begin
                            next_state_s = S_GAP;
                            gap_load_s   = 1'b1;
                        end
                    end else begin
                        next_state_s = S_WAIT_FALL;
                    end
                end
                S_GAP: begin
                    if (gap_zero_s) begin
                        next_state_s = S_TICK;
                    end else begin
                        next_state_s = S_GAP;
                    end
                end
                S_FINISH: next_state_s = S_IDLE;
                default:  next_state_s = S_IDLE;
            endcase
        end
    end

    // State register and the control outputs derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            wt_ready_r     <= 1'b0;
            program_mode_r <= 1'b0;
            start_tick_r   <= 1'b0;
            sched_busy_r   <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            wt_ready_r     <= (next_state_s == S_LOAD);
            program_mode_r <= (next_state_s == S_LOAD);
            start_tick_r   <= (next_state_s == S_TICK);
            sched_busy_r   <= (next_state_s != S_IDLE);
            done_r         <= (state_r == S_FINISH) && !abort;
        end
    end

    // Programming port: the core sees each accepted beat one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_r       <= {ADDR_W{1'b0}};
            prog_wr_en_r <= 1'b0;
            prog_addr_r  <= {ADDR_W{1'b0}};
            prog_data_r  <= {W_W{1'b0}};
        end else begin
            prog_wr_en_r <= beat_acc_s;
            if (beat_acc_s) begin
                prog_addr_r <= beat_r;
                prog_data_r <= wt_data;
                beat_r      <= beat_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else if ((state_r == S_IDLE) && load_start) begin
                beat_r <= {ADDR_W{1'b0}};
            end else begin
                beat_r <= beat_r;
            end
        end
    end

    // Run bookkeeping: results hold after done until the next accepted run_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_steps_r  <= {STEP_W{1'b0}};
            step_idx_r   <= {STEP_W{1'b0}};
            fire_count_r <= {CNT_W{1'b0}};
            fire_prev_r  <= 1'b0;
        end else begin
            fire_prev_r <= neuron_fire;
            if (run_go_s) begin
                num_steps_r  <= num_steps;
                step_idx_r   <= {STEP_W{1'b0}};
                fire_count_r <= {CNT_W{1'b0}};
            end else begin
                if (step_done_s) begin
                    step_idx_r <= step_next_s;
                end else begin
                    step_idx_r <= step_idx_r;
                end
                if (in_run(state_r) && neuron_fire && !fire_prev_r
                    && (fire_count_r != {CNT_W{1'b1}})) begin
                    fire_count_r <= fire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    fire_count_r <= fire_count_r;
                end
            end
        end
    end

    assign wt_ready     = wt_ready_r;
    assign program_mode = program_mode_r;
    assign prog_addr    = prog_addr_r;
    assign prog_data    = prog_data_r;
    assign prog_wr_en   = prog_wr_en_r;
    assign start_tick   = start_tick_r;
    assign step_idx     = step_idx_r;
    assign fire_count   = fire_count_r;
    assign sched_busy   = sched_busy_r;
    assign done         = done_r;

endmodule
